// File: rtl/sal_ddr_pkg.sv
// Shared types for the per-bank DRAM controller: bank states, command encoding, defaults.
// Width macros fall back to local defaults when the build does not provide them.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef DRAM_RA_WIDTH
`define DRAM_RA_WIDTH 14
`endif
`ifndef DRAM_CA_WIDTH
`define DRAM_CA_WIDTH 10
`endif
`ifndef DRAM_BA_WIDTH
`define DRAM_BA_WIDTH 3
`endif
`ifndef DRAM_ADDR_WIDTH
`define DRAM_ADDR_WIDTH 14
`endif
`ifndef T_RCD_WIDTH
`define T_RCD_WIDTH 4
`endif
`ifndef T_RP_WIDTH
`define T_RP_WIDTH 4
`endif
`ifndef T_RAS_WIDTH
`define T_RAS_WIDTH 6
`endif
`ifndef T_RFC_WIDTH
`define T_RFC_WIDTH 8
`endif
`ifndef T_RTP_WIDTH
`define T_RTP_WIDTH 4
`endif
`ifndef T_WTP_WIDTH
`define T_WTP_WIDTH 4
`endif

package sal_ddr_pkg;

  typedef enum logic [2:0] {
    BK_CLOSED      = 3'd0,
    BK_ACTIVATING  = 3'd1,
    BK_OPEN        = 3'd2,
    BK_COLUMN      = 3'd3,
    BK_PRECHARGING = 3'd4,
    BK_REFRESHING  = 3'd5
  } bk_state_e;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } bk_cmd_e;

  localparam int SAL_CA_STEP = 4;

endpackage

// File: rtl/sal_bk_timer.sv
// Loadable saturating down-counter: a load of t leaves the counter at max(t,1)-1,
// so zero rises exactly t cycles after the loading cycle.
module sal_bk_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt_r;

  // Count register: load on issue, then decrement and hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= (value == '0) ? '0 : value - W'(1);
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == '0);

endmodule

// File: rtl/sal_bank_ctrl.sv
// Per-bank open-page controller: holds one burst request, sequences ACT/RD/WR/PRE/REF
// under bank-local timing. Define SAL_BK_AUTO_PRE_EN for closed-page auto precharge.
module sal_bank_ctrl
  import sal_ddr_pkg::*;
#(
  parameter int BANK_ID = 0,
  parameter int CA_STEP = SAL_CA_STEP
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [`AXI_ID_WIDTH-1:0]    req_id,
  input  logic [`DRAM_RA_WIDTH-1:0]   req_ra,
  input  logic [`DRAM_CA_WIDTH-1:0]   req_ca,
  input  logic [3:0]                  req_len,
  input  logic                        req_wr,
  input  logic [`T_RCD_WIDTH-1:0]     t_rcd,
  input  logic [`T_RP_WIDTH-1:0]      t_rp,
  input  logic [`T_RAS_WIDTH-1:0]     t_ras,
  input  logic [`T_RFC_WIDTH-1:0]     t_rfc,
  input  logic [`T_RTP_WIDTH-1:0]     t_rtp,
  input  logic [`T_WTP_WIDTH-1:0]     t_wtp,
  input  logic                        ref_due,
  output logic                        act_req,
  output logic                        rd_req,
  output logic                        wr_req,
  output logic                        pre_req,
  output logic                        ref_req,
  input  logic                        act_gnt,
  input  logic                        rd_gnt,
  input  logic                        wr_gnt,
  input  logic                        pre_gnt,
  input  logic                        ref_gnt,
  output logic [`DRAM_BA_WIDTH-1:0]   ba,
  output logic [`DRAM_ADDR_WIDTH-1:0] addr,
  output logic [`AXI_ID_WIDTH-1:0]    cur_id
);

  localparam int AW  = `DRAM_ADDR_WIDTH;
  localparam int CAW = `DRAM_CA_WIDTH;
  localparam int BAW = `DRAM_BA_WIDTH;

  bk_state_e                  state_r, state_s;
  bk_cmd_e                    cmd_s;
  logic                       hold_r, wr_r, ref_pend_r;
  logic [`AXI_ID_WIDTH-1:0]   id_r;
  logic [`DRAM_RA_WIDTH-1:0]  ra_r, row_r;
  logic [CAW-1:0]             ca_r;
  logic [3:0]                 cnt_r;
  logic rcd_zero_s, rp_zero_s, ras_zero_s, rfc_zero_s, rtp_zero_s, wtp_zero_s;
  logic closed_like_s, open_like_s, hit_s, pre_ok_s, want_pre_s, last_s, accept_s;
  logic act_issue_s, rd_issue_s, wr_issue_s, pre_issue_s, ref_issue_s, col_issue_s;

  sal_bk_timer #(.W(`T_RCD_WIDTH)) u_rcd (.clk(clk), .rst_n(rst_n), .load(act_issue_s), .value(t_rcd), .zero(rcd_zero_s));
  sal_bk_timer #(.W(`T_RAS_WIDTH)) u_ras (.clk(clk), .rst_n(rst_n), .load(act_issue_s), .value(t_ras), .zero(ras_zero_s));
  sal_bk_timer #(.W(`T_RP_WIDTH))  u_rp  (.clk(clk), .rst_n(rst_n), .load(pre_issue_s), .value(t_rp),  .zero(rp_zero_s));
  sal_bk_timer #(.W(`T_RFC_WIDTH)) u_rfc (.clk(clk), .rst_n(rst_n), .load(ref_issue_s), .value(t_rfc), .zero(rfc_zero_s));
  sal_bk_timer #(.W(`T_RTP_WIDTH)) u_rtp (.clk(clk), .rst_n(rst_n), .load(rd_issue_s),  .value(t_rtp), .zero(rtp_zero_s));
  sal_bk_timer #(.W(`T_WTP_WIDTH)) u_wtp (.clk(clk), .rst_n(rst_n), .load(wr_issue_s),  .value(t_wtp), .zero(wtp_zero_s));

  // Waiting states whose timer has expired behave like the state they lead to,
  // so the next command goes out on the very cycle the timer reaches zero.
  always_comb begin
    closed_like_s = 1'b0;
    open_like_s   = 1'b0;
    case (state_r)
      BK_CLOSED:         closed_like_s = 1'b1;
      BK_PRECHARGING:    closed_like_s = rp_zero_s;
      BK_REFRESHING:     closed_like_s = rfc_zero_s;
      BK_ACTIVATING:     open_like_s   = rcd_zero_s;
      BK_OPEN, BK_COLUMN: open_like_s  = 1'b1;
      default: begin
        closed_like_s = 1'b0;
        open_like_s   = 1'b0;
      end
    endcase
  end

  // Command selection; commands are mutually exclusive by construction.
  always_comb begin
    hit_s    = hold_r && (row_r == ra_r);
    pre_ok_s = ras_zero_s && rtp_zero_s && wtp_zero_s;
`ifdef SAL_BK_AUTO_PRE_EN
    want_pre_s = !hit_s;
`else
    want_pre_s = hold_r ? !hit_s : ref_pend_r;
`endif
    cmd_s = CMD_NOP;
    if (closed_like_s) begin
      if (hold_r) begin
        cmd_s = CMD_ACT;
      end else if (ref_pend_r) begin
        cmd_s = CMD_REF;
      end else begin
        cmd_s = CMD_NOP;
      end
    end else if (open_like_s) begin
      if (hit_s) begin
        cmd_s = wr_r ? CMD_WR : CMD_RD;
      end else if (want_pre_s && pre_ok_s) begin
        cmd_s = CMD_PRE;
      end else begin
        cmd_s = CMD_NOP;
      end
    end else begin
      cmd_s = CMD_NOP;
    end
  end

  assign act_req = (cmd_s == CMD_ACT);
  assign rd_req  = (cmd_s == CMD_RD);
  assign wr_req  = (cmd_s == CMD_WR);
  assign pre_req = (cmd_s == CMD_PRE);
  assign ref_req = (cmd_s == CMD_REF);

  assign act_issue_s = act_req && act_gnt;
  assign rd_issue_s  = rd_req  && rd_gnt;
  assign wr_issue_s  = wr_req  && wr_gnt;
  assign pre_issue_s = pre_req && pre_gnt;
  assign ref_issue_s = ref_req && ref_gnt;
  assign col_issue_s = rd_issue_s || wr_issue_s;
  assign last_s      = (cnt_r == 4'd0);

  assign req_ready = (closed_like_s || open_like_s) && !hold_r && !ref_pend_r;
  assign accept_s  = req_valid && req_ready;
  assign ba        = BAW'(BANK_ID);
  assign cur_id    = id_r;

  // Address mux: row for ACT, current column for RD/WR, zero otherwise.
  always_comb begin
    addr = '0;
    case (cmd_s)
      CMD_ACT:        addr = AW'(ra_r);
      CMD_RD, CMD_WR: addr = AW'(ca_r);
      default:        addr = '0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      BK_CLOSED, BK_PRECHARGING, BK_REFRESHING: begin
        if (act_issue_s) begin
          state_s = BK_ACTIVATING;
        end else if (ref_issue_s) begin
          state_s = BK_REFRESHING;
        end else if (closed_like_s) begin
          state_s = BK_CLOSED;
        end else begin
          state_s = state_r;
        end
      end
      BK_ACTIVATING, BK_OPEN, BK_COLUMN: begin
        if (!open_like_s) begin
          state_s = state_r;
        end else if (pre_issue_s) begin
          state_s = BK_PRECHARGING;
        end else if (col_issue_s && last_s) begin
          state_s = BK_OPEN;
        end else if (hit_s) begin
          state_s = BK_COLUMN;
        end else begin
          state_s = BK_OPEN;
        end
      end
      default: state_s = BK_CLOSED;
    endcase
  end

  // State, held request, open row and refresh-pending registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= BK_CLOSED;
      hold_r     <= 1'b0;
      wr_r       <= 1'b0;
      id_r       <= '0;
      ra_r       <= '0;
      row_r      <= '0;
      ca_r       <= '0;
      cnt_r      <= 4'd0;
      ref_pend_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        hold_r <= 1'b1;
        wr_r   <= req_wr;
        id_r   <= req_id;
        ra_r   <= req_ra;
        ca_r   <= req_ca;
        cnt_r  <= req_len;
      end else if (col_issue_s) begin
        hold_r <= !last_s;
        ca_r   <= ca_r + CAW'(CA_STEP);
        cnt_r  <= last_s ? 4'd0 : cnt_r - 4'd1;
      end else begin
        hold_r <= hold_r;
      end
      if (act_issue_s) begin
        row_r <= ra_r;
      end else begin
        row_r <= row_r;
      end
      if (ref_issue_s) begin
        ref_pend_r <= 1'b0;
      end else if (ref_due) begin
        ref_pend_r <= 1'b1;
      end else begin
        ref_pend_r <= ref_pend_r;
      end
    end
  end

endmodule
